mac_feeder: RTL

MAC_FEEDER -- requirements
Module: mac_feeder

---
 rtl/mac_pkg.sv | 16 +
 rtl/skew_delay_line.sv | 31 +++
 rtl/mac_feeder.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/mac_pkg.sv
// Shared types and default sizes for the MAC array feeder.
// Holds the default lane count, lane width and the feeder state encoding.
package mac_pkg;

    localparam int MAC_ARR_SIZE = 4;
    localparam int MAC_HBW      = 16;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD_W,
        ST_STREAM,
        ST_FLUSH,
        ST_DONE
    } state_t;

endpackage

// File: rtl/skew_delay_line.sv
// Per-lane delay line: DEPTH+1 register stages from i_d to o_q.
// Ports: i_clk, i_rst_n (async active-low clear), i_d in, o_q out.
module skew_delay_line #(
    parameter int DEPTH = 0,
    parameter int WIDTH = 16
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    // Stage 0 is the output register every lane has; the rest skew.
    logic [WIDTH-1:0] r_pipe [DEPTH+1];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int k = 0; k <= DEPTH; k++) begin
                r_pipe[k] <= '0;
            end
        end else begin
            r_pipe[0] <= i_d;
            for (int k = 1; k <= DEPTH; k++) begin
                r_pipe[k] <= r_pipe[k-1];
            end
        end
    end

    assign o_q = r_pipe[DEPTH];

endmodule

// File: rtl/mac_feeder.sv
// Feeds a systolic MAC array: loads ARR_SIZE weight rows, then streams
// activation vectors with a diagonal lane skew, flushes and pulses done.
// Ports: clk/rst (async active-low), start/num_vec job request,
// w_* and a_* valid/ready inputs, vertical/horizontal array outputs,
// i_mode weight-beat flag, busy and done status.
module mac_feeder
    import mac_pkg::*;
#(
    parameter int ARR_SIZE      = MAC_ARR_SIZE,
    parameter int HORIZONTAL_BW = MAC_HBW
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              start,
    input  logic [7:0]                        num_vec,
    input  logic                              w_valid,
    output logic                              w_ready,
    input  logic [ARR_SIZE*HORIZONTAL_BW-1:0] w_data,
    input  logic                              a_valid,
    output logic                              a_ready,
    input  logic [ARR_SIZE*HORIZONTAL_BW-1:0] a_data,
    output logic [ARR_SIZE*HORIZONTAL_BW-1:0] vertical_input,
    output logic [ARR_SIZE*HORIZONTAL_BW-1:0] horizontal_input,
    output logic                              i_mode,
    output logic                              busy,
    output logic                              done
);

    localparam int VW = ARR_SIZE * HORIZONTAL_BW;
    localparam int CW = $clog2(ARR_SIZE + 1);

    state_t          r_state;
    state_t          w_next;
    logic [7:0]      r_num;
    logic [7:0]      r_acnt;
    logic [CW-1:0]   r_wcnt;
    logic [CW-1:0]   r_fcnt;
    logic [VW-1:0]   r_vert;
    logic            r_imode;
    logic            w_w_acc;
    logic            w_a_acc;

    assign w_w_acc = (r_state == ST_LOAD_W) && w_valid;
    assign w_a_acc = (r_state == ST_STREAM) && a_valid;

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_next = (num_vec == 8'd0) ? ST_DONE : ST_LOAD_W;
                end
            end
            ST_LOAD_W: begin
                if (w_w_acc && r_wcnt == CW'(ARR_SIZE - 1)) begin
                    w_next = ST_STREAM;
                end
            end
            ST_STREAM: begin
                if (w_a_acc && r_acnt == r_num - 8'd1) begin
                    w_next = ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                // One cycle beyond the deepest lane so the last sample
                // has been presented for a full cycle before done.
                if (r_fcnt == CW'(ARR_SIZE)) begin
                    w_next = ST_DONE;
                end
            end
            ST_DONE: w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
            r_num   <= '0;
            r_acnt  <= '0;
            r_wcnt  <= '0;
            r_fcnt  <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == ST_IDLE && start) begin
                r_num  <= num_vec;
                r_acnt <= '0;
                r_wcnt <= '0;
                r_fcnt <= '0;
            end
            if (w_w_acc) begin
                r_wcnt <= r_wcnt + CW'(1);
            end
            if (w_a_acc) begin
                r_acnt <= r_acnt + 8'd1;
            end
            if (r_state == ST_FLUSH) begin
                r_fcnt <= r_fcnt + CW'(1);
            end
        end
    end

    // Weight path: a missing beat becomes a zero bubble, never a stall.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_vert  <= '0;
            r_imode <= 1'b0;
        end else begin
            r_vert  <= w_w_acc ? w_data : '0;
            r_imode <= w_w_acc;
        end
    end

    // Lines shift every cycle; zeros go in unless a vector is accepted,
    // which keeps them empty outside of streaming.
    for (genvar i = 0; i < ARR_SIZE; i++) begin : g_lane
        logic [HORIZONTAL_BW-1:0] w_inj;

        assign w_inj = w_a_acc ?
            a_data[i*HORIZONTAL_BW +: HORIZONTAL_BW] : '0;

        skew_delay_line #(
            .DEPTH (i),
            .WIDTH (HORIZONTAL_BW)
        ) u_skew (
            .i_clk   (clk),
            .i_rst_n (rst),
            .i_d     (w_inj),
            .o_q     (horizontal_input[i*HORIZONTAL_BW +: HORIZONTAL_BW])
        );
    end

    assign vertical_input = r_vert;
    assign i_mode         = r_imode;
    assign w_ready        = (r_state == ST_LOAD_W);
    assign a_ready        = (r_state == ST_STREAM);
    assign busy           = (r_state == ST_LOAD_W) ||
                            (r_state == ST_STREAM) ||
                            (r_state == ST_FLUSH);
    assign done           = (r_state == ST_DONE);

endmodule
